// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, clog2 helper and index/counter types for the register file
package pipe_pkg;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 4;
  localparam int MAXINF_DEF = 3;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  typedef logic [AW_DEF-1:0] reg_idx_t;
  typedef logic [clog2(MAXINF_DEF+1)-1:0] cnt_t;
endpackage

// File: rtl/sb_counter.sv
// sb_counter: per-register in-flight write counter, saturating at MAX, never underflowing
module sb_counter
  import pipe_pkg::*;
#(
  parameter int MAX = MAXINF_DEF,
  parameter int CW  = clog2(MAX+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          nz
);
  logic d;
  assign d = dec & nz;
  assign full = cnt == CW'(MAX);
  assign nz = cnt != '0;
  always_ff @(posedge clk)
    if (!rst || clr) cnt <= '0;
    else if (inc && !d && !full) cnt <= cnt + 1'b1;
    else if (d && !inc) cnt <= cnt - 1'b1;
endmodule

// File: rtl/pipe_regfile_sb.sv
// pipe_regfile_sb: multi-read register file with write-back scoreboard and issue stall.
// Define PIPE_REGFILE_SB_BYPASS_EN for same-cycle write-through from the write-back port.
module pipe_regfile_sb
  import pipe_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int NRD    = 2,
  parameter int MAXINF = MAXINF_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  input  logic              iss_valid,
  input  logic              iss_wen,
  input  logic [AW-1:0]     iss_dst,
  output logic              iss_stall,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DW-1:0]     wb_data,
  output logic              pend_any
);
  localparam int NR = 2**AW;
  localparam int CW = clog2(MAXINF+1);
`ifdef PIPE_REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [DW-1:0] regs [NR];
  logic [CW-1:0] cnt [NR];
  logic [NR-1:0] full, nz, inc, dec;
  logic [NRD-1:0] h_src;
  logic acc, h_dst;
  always_ff @(posedge clk)
    if (!rst) for (int i = 0; i < NR; i++) regs[i] <= '0;
    else if (wb_valid && wb_addr != '0) regs[wb_addr] <= wb_data;
  // register 0 has no counter so it can never stall or report pending
  genvar r;
  for (r = 0; r < NR; r++) begin : g_sb
    if (r == 0) begin : g_zero
      assign cnt[r] = '0;
      assign full[r] = 1'b0;
      assign nz[r] = 1'b0;
      assign inc[r] = 1'b0;
      assign dec[r] = 1'b0;
    end else begin : g_cnt
      assign inc[r] = acc & iss_wen & ~flush & (iss_dst == AW'(r));
      assign dec[r] = wb_valid & (wb_addr == AW'(r));
      sb_counter #(.MAX(MAXINF), .CW(CW)) u_cnt (
        .clk(clk), .rst(rst), .inc(inc[r]), .dec(dec[r]), .clr(flush),
        .cnt(cnt[r]), .full(full[r]), .nz(nz[r])
      );
    end
  end
  genvar k;
  for (k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic hit;
    assign a = rd_addr[k*AW +: AW];
    assign hit = BYP && wb_valid && wb_addr == a && a != '0;
    assign h_src[k] = nz[a] && !(hit && cnt[a] == CW'(1));
    assign rd_data[k*DW +: DW] = a == '0 ? '0 : hit ? wb_data : regs[a];
  end
  assign h_dst = iss_wen & full[iss_dst];
  assign iss_stall = rst & iss_valid & (|h_src | h_dst);
  assign acc = iss_valid & ~iss_stall;
  assign pend_any = rst & |nz;
endmodule

// File: tb/tb_pipe_regfile_sb.sv
// tb_pipe_regfile_sb: directed vector table plus randomized run against a reference model
module tb_pipe_regfile_sb;
  localparam int DW = 16, AW = 4, NRD = 2, MAXINF = 3;
`ifdef PIPE_REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic iss_valid, iss_wen, iss_stall, flush, wb_valid, pend_any;
  logic [AW-1:0] iss_dst, wb_addr;
  logic [DW-1:0] wb_data;
  int n_run = 0, n_fail = 0;
  int m_cnt [16];
  logic [15:0] m_reg [16];

  pipe_regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD), .MAXINF(MAXINF)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_dst(iss_dst), .iss_stall(iss_stall),
    .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .pend_any(pend_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, v, w;
    logic [3:0] dst;
    logic fl, wv;
    logic [3:0] wa;
    logic [15:0] wd;
    logic [3:0] a0, a1;
    logic ck, es, ep;
    logic [15:0] e0, e1;
  } vec_t;

  function automatic vec_t mk(input int r, v, w, dst, fl, wv, wa, wd, a0, a1, ck, es, ep, e0, e1);
    vec_t t;
    t.r = 1'(r); t.v = 1'(v); t.w = 1'(w); t.dst = 4'(dst); t.fl = 1'(fl);
    t.wv = 1'(wv); t.wa = 4'(wa); t.wd = 16'(wd); t.a0 = 4'(a0); t.a1 = 4'(a1);
    t.ck = 1'(ck); t.es = 1'(es); t.ep = 1'(ep); t.e0 = 16'(e0); t.e1 = 16'(e1);
    return t;
  endfunction

  function automatic logic m_stall();
    logic [3:0] a;
    if (!rst || !iss_valid) return 1'b0;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*AW +: AW];
      if (a != 0 && m_cnt[a] > 0 && !(BYP && m_cnt[a] == 1 && wb_valid && wb_addr == a)) return 1'b1;
    end
    return iss_wen && iss_dst != 0 && m_cnt[iss_dst] == MAXINF;
  endfunction

  function automatic logic [15:0] m_rd(input logic [3:0] a);
    if (a == 0) return 16'h0;
    if (BYP && wb_valid && wb_addr == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic logic m_pend();
    if (!rst) return 1'b0;
    foreach (m_cnt[i]) if (m_cnt[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_update(input logic s);
    logic d;
    if (!rst) begin
      foreach (m_cnt[i]) begin m_cnt[i] = 0; m_reg[i] = 16'h0; end
    end else begin
      d = wb_valid && wb_addr != 0 && m_cnt[wb_addr] > 0;
      if (flush) foreach (m_cnt[i]) m_cnt[i] = 0;
      else begin
        if (iss_valid && !s && iss_wen && iss_dst != 0) m_cnt[iss_dst]++;
        if (d) m_cnt[wb_addr]--;
      end
      if (wb_valid && wb_addr != 0) m_reg[wb_addr] = wb_data;
    end
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, got, want);
    end
  endtask

  task automatic cycle(input vec_t t, input bit tab, input int row);
    logic s;
    @(negedge clk);
    rst = t.r; iss_valid = t.v; iss_wen = t.w; iss_dst = t.dst; flush = t.fl;
    wb_valid = t.wv; wb_addr = t.wa; wb_data = t.wd; rd_addr = {t.a1, t.a0};
    #1;
    s = m_stall();
    if (tab) begin
      chk("stall", row, iss_stall, t.es);
      chk("pend", row, pend_any, t.ep);
      if (t.ck) begin
        chk("rd0", row, rd_data[15:0], t.e0);
        chk("rd1", row, rd_data[31:16], t.e1);
      end
    end else begin
      chk("rstall", row, iss_stall, s);
      chk("rpend", row, pend_any, m_pend());
      chk("rrd0", row, rd_data[15:0], m_rd(t.a0));
      chk("rrd1", row, rd_data[31:16], m_rd(t.a1));
    end
    @(posedge clk);
    m_update(s);
  endtask

  initial begin
    vec_t tv[$];
    rst = 1'b0; iss_valid = 1'b0; iss_wen = 1'b0; iss_dst = '0; flush = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; rd_addr = '0;
    // reset overriding a write-back
    tv.push_back(mk(0,0,0,0,0,1,3,'hBEEF,3,0,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,1,3,'hBEEF,3,0,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,3,0,1,0,0,0,0));
    // RAW on R5
    tv.push_back(mk(1,1,1,5,0,0,0,0,0,0,1,0,0,0,0));
    tv.push_back(mk(1,1,0,0,0,0,0,0,5,0,1,1,1,0,0));
    tv.push_back(mk(1,1,0,0,0,0,0,0,5,0,1,1,1,0,0));
    tv.push_back(mk(1,1,0,0,0,1,5,'h1234,5,0,1,!BYP,1,BYP ? 'h1234 : 0,0));
    tv.push_back(mk(1,1,0,0,0,0,0,0,5,0,1,0,0,'h1234,0));
    // WAW saturation on R7
    tv.push_back(mk(1,1,1,7,0,0,0,0,0,0,1,0,0,0,0));
    tv.push_back(mk(1,1,1,7,0,0,0,0,0,0,1,0,1,0,0));
    tv.push_back(mk(1,1,1,7,0,0,0,0,0,0,1,0,1,0,0));
    tv.push_back(mk(1,1,1,7,0,0,0,0,0,0,1,1,1,0,0));
    tv.push_back(mk(1,1,1,7,0,1,7,'h0707,0,0,1,1,1,0,0));
    tv.push_back(mk(1,1,1,7,0,0,0,0,0,0,1,0,1,0,0));
    for (int i = 0; i < 3; i++) tv.push_back(mk(1,0,0,0,0,1,7,'h0777,0,0,1,0,1,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,7,5,1,0,0,'h0777,'h1234));
    // simultaneous inc/dec on R2
    tv.push_back(mk(1,1,1,2,0,0,0,0,0,0,1,0,0,0,0));
    tv.push_back(mk(1,1,1,2,0,1,2,'h0022,0,0,1,0,1,0,0));
    tv.push_back(mk(1,1,0,0,0,0,0,0,2,0,1,1,1,'h0022,0));
    tv.push_back(mk(1,0,0,0,0,1,2,'h2222,2,0,1,0,1,BYP ? 'h2222 : 'h0022,0));
    tv.push_back(mk(1,1,0,0,0,0,0,0,2,0,1,0,0,'h2222,0));
    // R0 is never tracked nor written
    tv.push_back(mk(1,1,1,0,0,1,0,'hFFFF,0,0,1,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,0,0,0,0));
    // flush with an accepted issue
    tv.push_back(mk(1,1,1,4,0,0,0,0,0,0,1,0,0,0,0));
    tv.push_back(mk(1,1,1,4,0,0,0,0,0,0,1,0,1,0,0));
    tv.push_back(mk(1,1,1,9,0,0,0,0,0,0,1,0,1,0,0));
    tv.push_back(mk(1,1,1,4,1,0,0,0,0,0,1,0,1,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,4,9,1,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,1,4,'h00AA,4,0,1,0,0,BYP ? 'h00AA : 0,0));
    tv.push_back(mk(1,1,0,0,0,0,0,0,4,9,1,0,0,'h00AA,0));
    // reset mid-operation
    tv.push_back(mk(0,1,1,3,0,1,6,1,0,0,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,4,6,1,0,0,0,0));
    foreach (tv[i]) cycle(tv[i], 1'b1, i);
    for (int i = 0; i < 1500; i++)
      cycle(mk($urandom_range(63) != 0, $urandom_range(1), $urandom_range(1), $urandom_range(7),
               $urandom_range(15) == 0, $urandom_range(1), $urandom_range(7), $urandom_range(16'hFFFF),
               $urandom_range(7), $urandom_range(7), 1, 0, 0, 0, 0), 1'b0, i);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
